ppu_vram_arb: RTL and testbench

//  Arbitrates and sequences the single PPU VRAM port among three requesters: background fetcher (bg),

---
 rtl/ppu_vram_arb_if.sv | 40 ++++
 rtl/ppu_vram_arb.sv | 144 ++++++++++++++
 tb/tb_ppu_vram_arb.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_vram_arb_if.sv
// Bundle between the VRAM arbiter and its requesters (bg fetcher, sprite engine, CPU $2007 path) and the VRAM.
// The arbiter takes the slave side; the environment (requesters + RAM) takes the master side.
interface ppu_vram_arb_if;
  logic [8:0]  cycleNum;
  logic        render_en;
  logic        vblank;
  logic        bg2vram_v;
  logic [13:0] bg2vram_addr;
  logic [7:0]  vram2bg_data;
  logic        se2vram_v;
  logic [13:0] se2vram_addr;
  logic [7:0]  vram2se_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic        vram_wr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic [1:0]  owner;

  modport master (
    output cycleNum, render_en, vblank, bg2vram_v, bg2vram_addr, se2vram_v, se2vram_addr,
           cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    input  vram2bg_data, vram2se_data, cpu_ack, cpu_rdata, cpu_stall,
           vram_addr, vram_rd, vram_wr, vram_wdata, owner
  );

  modport slave (
    input  cycleNum, render_en, vblank, bg2vram_v, bg2vram_addr, se2vram_v, se2vram_addr,
           cpu_req, cpu_we, cpu_addr, cpu_wdata, vram_rdata,
    output vram2bg_data, vram2se_data, cpu_ack, cpu_rdata, cpu_stall,
           vram_addr, vram_rd, vram_wr, vram_wdata, owner
  );
endinterface

// File: rtl/ppu_vram_arb.sv
// Sequences the single PPU VRAM port: bg/se by scanline dot window while rendering, CPU otherwise.
// Grant -> address phase next cycle -> data/ack the cycle after; blocked requesters wait (cpu_stall flags the CPU).
module ppu_vram_arb #(
  parameter logic [8:0] SE_FIRST = 9'd257,
  parameter logic [8:0] SE_LAST  = 9'd320,
  parameter logic [8:0] LAST_DOT = 9'd340
) (
  input logic           clock,
  input logic           reset_n,
  ppu_vram_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_BG   = 2'd1;
  localparam logic [1:0] OWN_SE   = 2'd2;
  localparam logic [1:0] OWN_CPU  = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  owner_q;
  logic        we_q;
  logic [13:0] addr_q;
  logic [7:0]  wdata_q;
  logic        rd_q, wr_q;
  logic [7:0]  bg_q, se_q, cpu_q;

  logic        rendering, in_bg, in_se, slot_free, cpu_retiring;
  logic [1:0]  grant;
  logic [13:0] grant_addr;
  logic        grant_wr;

  assign rendering = bus.render_en & ~bus.vblank;
  assign in_se     = (bus.cycleNum >= SE_FIRST) && (bus.cycleNum <= SE_LAST);
  assign in_bg     = ((bus.cycleNum >= 9'd1) && (bus.cycleNum < SE_FIRST)) ||
                     ((bus.cycleNum > SE_LAST) && (bus.cycleNum <= LAST_DOT));
  assign slot_free = (state_q == IDLE) || (state_q == DATA);
  // cpu_req is still high in its own ack cycle; it must not count as a fresh request.
  assign cpu_retiring = (state_q == DATA) && (owner_q == OWN_CPU);

  always_comb begin
    grant = OWN_NONE;
    if (slot_free) begin
      if (rendering) begin
        if (in_bg && bus.bg2vram_v)
          grant = OWN_BG;
        else if (in_se && bus.se2vram_v)
          grant = OWN_SE;
      end else if (bus.cpu_req && !cpu_retiring) begin
        grant = OWN_CPU;
      end
    end
  end

  always_comb begin
    grant_addr = bus.cpu_addr;
    case (grant)
      OWN_BG:  grant_addr = bus.bg2vram_addr;
      OWN_SE:  grant_addr = bus.se2vram_addr;
      default: grant_addr = bus.cpu_addr;
    endcase
  end

  assign grant_wr = (grant == OWN_CPU) & bus.cpu_we;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (grant != OWN_NONE) ? ADDR : IDLE;
      ADDR:    state_d = DATA;
      DATA:    state_d = (grant != OWN_NONE) ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address-phase strobes are registered so they are clean for exactly the ADDR cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      bg_q    <= '0;
      se_q    <= '0;
      cpu_q   <= '0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      if (grant != OWN_NONE) begin
        owner_q <= grant;
        we_q    <= grant_wr;
        addr_q  <= grant_addr;
        rd_q    <= ~grant_wr;
        wr_q    <= grant_wr;
        if (grant_wr)
          wdata_q <= bus.cpu_wdata;
      end else if (state_q == DATA) begin
        owner_q <= OWN_NONE;
      end

      if (state_q == DATA) begin
        case (owner_q)
          OWN_BG:  bg_q <= bus.vram_rdata;
          OWN_SE:  se_q <= bus.vram_rdata;
          OWN_CPU: if (!we_q) cpu_q <= bus.vram_rdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.vram_addr    = addr_q;
    bus.vram_rd      = rd_q;
    bus.vram_wr      = wr_q;
    bus.vram_wdata   = wdata_q;
    bus.owner        = owner_q;
    bus.cpu_ack      = cpu_retiring;
    bus.vram2bg_data = bg_q;
    bus.vram2se_data = se_q;
    bus.cpu_rdata    = cpu_q;
    if (state_q == DATA && owner_q == OWN_BG)
      bus.vram2bg_data = bus.vram_rdata;
    if (state_q == DATA && owner_q == OWN_SE)
      bus.vram2se_data = bus.vram_rdata;
    if (cpu_retiring && !we_q)
      bus.cpu_rdata = bus.vram_rdata;
    bus.cpu_stall = reset_n & bus.cpu_req & rendering & (owner_q != OWN_CPU);
  end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Self-checking bench for ppu_vram_arb: directed scenarios plus a randomized run against a dot-window model.
module tb_ppu_vram_arb;
  logic clock;
  logic reset_n;
  ppu_vram_arb_if bus();

  ppu_vram_arb dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] init_pat(input logic [13:0] a);
    if (a == 14'h2005) return 8'h5A;
    if (a == 14'h1230) return 8'hC3;
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  // Synchronous RAM: data appears the cycle after the address strobe.
  logic [7:0] ram_d [16384];
  bit         ram_v [16384];
  always @(posedge clock) begin
    if (bus.vram_wr) begin
      ram_d[bus.vram_addr] <= bus.vram_wdata;
      ram_v[bus.vram_addr] <= 1'b1;
    end
    if (bus.vram_rd)
      bus.vram_rdata <= ram_v[bus.vram_addr] ? ram_d[bus.vram_addr] : init_pat(bus.vram_addr);
  end

  // Reference memory contents as the bench expects them.
  logic [7:0] ref_d [16384];
  bit         ref_v [16384];
  function automatic logic [7:0] ref_rd(input logic [13:0] a);
    return ref_v[a] ? ref_d[a] : init_pat(a);
  endfunction

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    bus.cpu_req = 1'b1; bus.render_en = 1'b1; bus.vblank = 1'b0;
    bus.cycleNum = 9'd100; bus.bg2vram_v = 1'b1;
    tick(); tick();
    n_cmp++; if (bus.owner !== 2'd0) begin n_err++; $display("FAIL reset_owner got %0d want 0", bus.owner); end
    n_cmp++; if ({bus.vram_rd, bus.vram_wr} !== 2'b00) begin n_err++; $display("FAIL reset_strobes got %b want 00", {bus.vram_rd, bus.vram_wr}); end
    n_cmp++; if ({bus.cpu_ack, bus.cpu_stall} !== 2'b00) begin n_err++; $display("FAIL reset_ack_stall got %b want 00", {bus.cpu_ack, bus.cpu_stall}); end
    n_cmp++; if (bus.vram_addr !== 14'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", bus.vram_addr); end
    n_cmp++; if ({bus.vram_wdata, bus.cpu_rdata, bus.vram2bg_data, bus.vram2se_data} !== 32'h0) begin
      n_err++; $display("FAIL reset_data got %h want 0", {bus.vram_wdata, bus.cpu_rdata, bus.vram2bg_data, bus.vram2se_data}); end
    bus.cpu_req = 1'b0; bus.bg2vram_v = 1'b0; bus.render_en = 1'b0;
    reset_n = 1'b1;
    tick();
    n_cmp++; if (bus.owner !== 2'd0) begin n_err++; $display("FAIL post_reset_idle got %0d want 0", bus.owner); end
  endtask

  task automatic test_cpu_read;
    bus.render_en = 1'b0; bus.vblank = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h2005;
    tick();
    n_cmp++; if ({bus.owner, bus.vram_rd, bus.vram_wr, bus.cpu_ack} !== 5'b11_1_0_0) begin
      n_err++; $display("FAIL cpurd_addr_phase got %b want 11100", {bus.owner, bus.vram_rd, bus.vram_wr, bus.cpu_ack}); end
    n_cmp++; if (bus.vram_addr !== 14'h2005) begin n_err++; $display("FAIL cpurd_addr got %h want 2005", bus.vram_addr); end
    tick();
    n_cmp++; if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 8'h5A}) begin
      n_err++; $display("FAIL cpurd_ack got ack=%b rdata=%h want ack=1 rdata=5a", bus.cpu_ack, bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    tick();
    n_cmp++; if ({bus.cpu_ack, bus.owner, bus.vram_rd, bus.cpu_rdata} !== {1'b0, 2'd0, 1'b0, 8'h5A}) begin
      n_err++; $display("FAIL cpurd_done got ack=%b owner=%0d rd=%b rdata=%h want 0 0 0 5a", bus.cpu_ack, bus.owner, bus.vram_rd, bus.cpu_rdata); end
  endtask

  task automatic test_bg_render;
    bus.render_en = 1'b1; bus.vblank = 1'b0; bus.cycleNum = 9'd100;
    bus.bg2vram_v = 1'b1; bus.bg2vram_addr = 14'h1230;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0001;
    tick();
    n_cmp++; if ({bus.owner, bus.vram_rd, bus.cpu_stall} !== 4'b01_1_1) begin
      n_err++; $display("FAIL bg_addr_phase got %b want 0111", {bus.owner, bus.vram_rd, bus.cpu_stall}); end
    n_cmp++; if (bus.vram_addr !== 14'h1230) begin n_err++; $display("FAIL bg_addr got %h want 1230", bus.vram_addr); end
    bus.bg2vram_v = 1'b0;
    tick();
    n_cmp++; if ({bus.vram2bg_data, bus.cpu_ack, bus.cpu_stall} !== {8'hC3, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL bg_data got data=%h ack=%b stall=%b want c3 0 1", bus.vram2bg_data, bus.cpu_ack, bus.cpu_stall); end
    tick();
    n_cmp++; if ({bus.owner, bus.vram2bg_data, bus.cpu_ack, bus.cpu_stall} !== {2'd0, 8'hC3, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL bg_hold got owner=%0d data=%h ack=%b stall=%b want 0 c3 0 1", bus.owner, bus.vram2bg_data, bus.cpu_ack, bus.cpu_stall); end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_window_edge;
    bus.render_en = 1'b1; bus.cycleNum = 9'd255;
    bus.bg2vram_v = 1'b1; bus.bg2vram_addr = 14'h0AAA;
    bus.se2vram_v = 1'b0; bus.se2vram_addr = 14'h1555;
    tick();
    bus.cycleNum = 9'd256; bus.se2vram_v = 1'b1;
    n_cmp++; if ({bus.owner, bus.vram_rd} !== 3'b01_1) begin n_err++; $display("FAIL edge_bg_addr got %b want 011", {bus.owner, bus.vram_rd}); end
    tick();
    bus.cycleNum = 9'd257;
    n_cmp++; if ({bus.owner, bus.vram_rd, bus.vram2bg_data} !== {2'd1, 1'b0, init_pat(14'h0AAA)}) begin
      n_err++; $display("FAIL edge_bg_data got owner=%0d rd=%b data=%h want 1 0 %h", bus.owner, bus.vram_rd, bus.vram2bg_data, init_pat(14'h0AAA)); end
    tick();
    bus.cycleNum = 9'd258; bus.se2vram_v = 1'b0; bus.bg2vram_v = 1'b0;
    n_cmp++; if ({bus.owner, bus.vram_rd, bus.vram_addr} !== {2'd2, 1'b1, 14'h1555}) begin
      n_err++; $display("FAIL edge_se_addr got owner=%0d rd=%b addr=%h want 2 1 1555", bus.owner, bus.vram_rd, bus.vram_addr); end
    tick();
    n_cmp++; if (bus.vram2se_data !== init_pat(14'h1555)) begin
      n_err++; $display("FAIL edge_se_data got %h want %h", bus.vram2se_data, init_pat(14'h1555)); end
    tick();
  endtask

  task automatic test_se_burst;
    int n_addr = 0;
    bus.render_en = 1'b1; bus.vblank = 1'b0; bus.bg2vram_v = 1'b0;
    bus.se2vram_v = 1'b1; bus.cycleNum = 9'd257;
    for (int d = 258; d <= 322; d++) begin
      tick();
      bus.cycleNum = 9'(d);
      bus.se2vram_addr = 14'($urandom_range(16383));
      if (d <= 321) begin
        n_cmp++; if ({bus.owner, bus.vram_rd} !== {2'd2, d % 2 == 0}) begin
          n_err++; $display("FAIL se_burst dot=%0d got owner=%0d rd=%b want 2 %0d", d, bus.owner, bus.vram_rd, d % 2 == 0); end
        if (bus.vram_rd) n_addr++;
      end else begin
        n_cmp++; if (bus.owner !== 2'd0) begin n_err++; $display("FAIL se_burst_end got %0d want 0", bus.owner); end
      end
    end
    n_cmp++; if (n_addr !== 32) begin n_err++; $display("FAIL se_burst_count got %0d want 32", n_addr); end
    bus.se2vram_v = 1'b0;
  endtask

  task automatic test_cpu_write_vblank;
    bus.render_en = 1'b1; bus.vblank = 1'b0; bus.cycleNum = 9'd100;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h3F00; bus.cpu_wdata = 8'h21;
    tick();
    n_cmp++; if ({bus.cpu_stall, bus.owner, bus.vram_wr} !== 4'b1_00_0) begin
      n_err++; $display("FAIL wr_blocked got %b want 1000", {bus.cpu_stall, bus.owner, bus.vram_wr}); end
    bus.vblank = 1'b1;
    tick();
    n_cmp++; if ({bus.vram_wr, bus.vram_rd, bus.owner, bus.cpu_stall} !== 5'b1_0_11_0) begin
      n_err++; $display("FAIL wr_addr_phase got %b want 10110", {bus.vram_wr, bus.vram_rd, bus.owner, bus.cpu_stall}); end
    n_cmp++; if ({bus.vram_addr, bus.vram_wdata} !== {14'h3F00, 8'h21}) begin
      n_err++; $display("FAIL wr_addr_data got %h %h want 3f00 21", bus.vram_addr, bus.vram_wdata); end
    tick();
    n_cmp++; if ({bus.vram_wr, bus.cpu_ack, bus.cpu_rdata} !== {1'b0, 1'b1, 8'h5A}) begin
      n_err++; $display("FAIL wr_ack got wr=%b ack=%b rdata=%h want 0 1 5a", bus.vram_wr, bus.cpu_ack, bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    ref_d[14'h3F00] = 8'h21; ref_v[14'h3F00] = 1'b1;
    tick();
    n_cmp++; if ({bus.vram_wr, bus.cpu_ack} !== 2'b00) begin n_err++; $display("FAIL wr_single got %b want 00", {bus.vram_wr, bus.cpu_ack}); end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    tick(); tick();
    n_cmp++; if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 8'h21}) begin
      n_err++; $display("FAIL wr_readback got ack=%b rdata=%h want 1 21", bus.cpu_ack, bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_addr;
    bus.render_en = 1'b0; bus.vblank = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0123;
    tick();
    n_cmp++; if (bus.vram_rd !== 1'b1) begin n_err++; $display("FAIL rst_pre_addr got rd=%b want 1", bus.vram_rd); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({bus.owner, bus.vram_rd, bus.vram_wr, bus.cpu_ack, bus.cpu_stall, bus.vram_addr, bus.cpu_rdata} !== 28'h0) begin
      n_err++; $display("FAIL rst_mid_addr got owner=%0d rd=%b addr=%h rdata=%h want all 0", bus.owner, bus.vram_rd, bus.vram_addr, bus.cpu_rdata); end
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++; if ({bus.owner, bus.vram_rd, bus.vram_addr} !== {2'd3, 1'b1, 14'h0123}) begin
      n_err++; $display("FAIL rst_regrant got owner=%0d rd=%b addr=%h want 3 1 0123", bus.owner, bus.vram_rd, bus.vram_addr); end
    tick();
    n_cmp++; if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, ref_rd(14'h0123)}) begin
      n_err++; $display("FAIL rst_regrant_data got ack=%b rdata=%h want 1 %h", bus.cpu_ack, bus.cpu_rdata, ref_rd(14'h0123)); end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  // Randomized run: one access is an address cycle followed by a data cycle; grants follow the dot map.
  task automatic test_random;
    int          m_phase, m_who, g;
    logic [13:0] m_addr;
    bit          m_we, rend, inbg, inse;
    logic [7:0]  m_wdata, m_bg, m_se, m_cpu, rv;
    logic [51:0] exp_v, act_v;
    int          cn;
    reset_n = 1'b0;
    bus.cpu_req = 1'b0; bus.bg2vram_v = 1'b0; bus.se2vram_v = 1'b0;
    bus.render_en = 1'b0; bus.vblank = 1'b0; bus.cycleNum = 9'd0;
    tick();
    reset_n = 1'b1;
    m_phase = 0; m_who = 0; m_addr = '0; m_we = 1'b0;
    m_wdata = '0; m_bg = '0; m_se = '0; m_cpu = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      cn   = int'(bus.cycleNum);
      rend = bus.render_en && !bus.vblank;
      inbg = (cn >= 1 && cn <= 256) || (cn >= 321 && cn <= 340);
      inse = (cn >= 257 && cn <= 320);
      g = 0;
      if (m_phase != 1) begin
        if (rend) begin
          if (inbg && bus.bg2vram_v) g = 1;
          else if (inse && bus.se2vram_v) g = 2;
        end else if (bus.cpu_req && !(m_phase == 2 && m_who == 3)) begin
          g = 3;
        end
      end
      if (m_phase == 2) begin
        rv = ref_rd(m_addr);
        if (m_who == 1) m_bg = rv;
        if (m_who == 2) m_se = rv;
        if (m_who == 3 && !m_we) m_cpu = rv;
      end
      if (m_phase == 1) begin
        if (m_we) begin ref_d[m_addr] = m_wdata; ref_v[m_addr] = 1'b1; end
        m_phase = 2;
      end else if (g != 0) begin
        m_phase = 1; m_who = g;
        m_addr = (g == 1) ? bus.bg2vram_addr : (g == 2) ? bus.se2vram_addr : bus.cpu_addr;
        m_we = (g == 3) && bus.cpu_we;
        if (m_we) m_wdata = bus.cpu_wdata;
      end else begin
        m_phase = 0; m_who = 0;
      end

      rv = ref_rd(m_addr);
      exp_v = {2'(m_who), m_phase == 1 && !m_we, m_phase == 1 && m_we, m_addr, m_wdata,
               m_phase == 2 && m_who == 3,
               (m_phase == 2 && m_who == 3 && !m_we) ? rv : m_cpu,
               (m_phase == 2 && m_who == 1) ? rv : m_bg,
               (m_phase == 2 && m_who == 2) ? rv : m_se,
               bus.cpu_req && rend && m_who != 3};
      act_v = {bus.owner, bus.vram_rd, bus.vram_wr, bus.vram_addr, bus.vram_wdata, bus.cpu_ack,
               bus.cpu_rdata, bus.vram2bg_data, bus.vram2se_data, bus.cpu_stall};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL random cyc=%0d dot=%0d got %h want %h", cyc, cn, act_v, exp_v);
      end

      if (m_phase == 2 && m_who == 3) begin
        bus.cpu_req = 1'b0;
      end else if (!bus.cpu_req && $urandom_range(3) == 0) begin
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'($urandom_range(1));
        bus.cpu_addr  = 14'h3F00 + 14'($urandom_range(15));
        bus.cpu_wdata = 8'($urandom);
      end
      if ($urandom_range(19) == 0) bus.cycleNum = 9'($urandom_range(511));
      else bus.cycleNum = (cn >= 340) ? 9'd0 : 9'(cn + 1);
      if ($urandom_range(39) == 0) bus.render_en = ~bus.render_en;
      if ($urandom_range(39) == 0) bus.vblank = ~bus.vblank;
      bus.bg2vram_v    = $urandom_range(3) != 0;
      bus.bg2vram_addr = 14'($urandom_range(16383));
      bus.se2vram_v    = $urandom_range(3) != 0;
      bus.se2vram_addr = 14'($urandom_range(16383));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    bus.cycleNum = 9'd0; bus.render_en = 1'b0; bus.vblank = 1'b0;
    bus.bg2vram_v = 1'b0; bus.bg2vram_addr = '0;
    bus.se2vram_v = 1'b0; bus.se2vram_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    test_reset();
    test_cpu_read();
    test_bg_render();
    test_window_edge();
    test_se_burst();
    test_cpu_write_vblank();
    test_reset_mid_addr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
